// File: rtl/pkt_seq_pkg.sv
// Shared state encoding and ctrl-byte decode for the packet sequencer.
package pkt_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StProc,
        StTx,
        StDrop
    } state_e;

    localparam logic [7:0] SopCtrlDefault = 8'hFF;

    // Payload words carry this ctrl value; any other value except the SOP code closes a packet.
    localparam logic [7:0] CtrlData = 8'h00;

    function automatic logic is_eop(input logic [7:0] ctrl, input logic [7:0] sop_ctrl);
        return (ctrl != CtrlData) && (ctrl != sop_ctrl);
    endfunction

endpackage

// File: rtl/pkt_seq_timer.sv
// Saturating ownership timer for the PROC phase; flags the last allowed cycle.
module pkt_seq_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] Last = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Last)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == Last);

endmodule

// File: rtl/pkt_seq_ctrl.sv
// Packet sequencer: tracks one packet from SOP through processor ownership to drain or drop.
module pkt_seq_ctrl
    import pkt_seq_pkg::*;
#(
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned MAX_LEN  = 200,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [7:0]  SOP_CTRL = SopCtrlDefault
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [7:0]      wr_ctrl,
    input  logic            fifo_full,
    input  logic [AWIDTH:0] tail_addr,
    input  logic            proc_done,
    input  logic            proc_drop,
    input  logic            tx_ready,
    output logic            fifo_sel,
    output logic            rd_en,
    output logic            drop_packet,
    output logic            stall,
    output logic            tx_valid,
    output logic            tx_last,
    output logic [AWIDTH:0] pkt_base,
    output logic [AWIDTH:0] pkt_len,
    output logic            err
);

    localparam int unsigned   PW     = AWIDTH + 1;
    localparam int unsigned   LenCap = (1 << PW) - 1;
    localparam logic [PW-1:0] LenMax = {PW{1'b1}};
    localparam logic [PW-1:0] MaxLen = PW'((MAX_LEN < LenCap) ? MAX_LEN : LenCap);
    localparam logic [PW-1:0] One    = PW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] pkt_len_q, pkt_len_d;
    logic [PW-1:0] pkt_base_q, pkt_base_d;
    logic [PW-1:0] rd_cnt_q, rd_cnt_d;
    logic [PW-1:0] len_next;
    logic          err_q, err_d;
    logic          tx_valid_q, tx_last_q;
    logic          wr_sop, wr_eop, last_rd;
    logic          timer_clear, timer_enable, timer_expired;

    assign wr_sop   = (wr_ctrl == SOP_CTRL);
    assign wr_eop   = is_eop(wr_ctrl, SOP_CTRL);
    assign len_next = (pkt_len_q == LenMax) ? pkt_len_q : pkt_len_q + One;

    pkt_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        pkt_len_d    = pkt_len_q;
        pkt_base_d   = pkt_base_q;
        rd_cnt_d     = rd_cnt_q;
        err_d        = err_q;
        fifo_sel     = 1'b0;
        stall        = 1'b1;
        rd_en        = 1'b0;
        drop_packet  = 1'b0;
        last_rd      = 1'b0;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = 1'b0;
                if (wr_en) begin
                    if (wr_sop) begin
                        pkt_base_d = tail_addr;
                        pkt_len_d  = One;
                        state_d    = wr_eop ? StProc : StRecv;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
            end
            StRecv: begin
                stall = 1'b0;
                if (fifo_full) begin
                    err_d   = 1'b1;
                    state_d = StDrop;
                end else if (wr_en) begin
                    if (wr_sop) begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end else begin
                        pkt_len_d = len_next;
                        if (wr_eop) begin
                            state_d = StProc;
                        end else if (len_next >= MaxLen) begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end
                end
            end
            StProc: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (proc_drop) begin
                    state_d = StDrop;
                end else if (proc_done) begin
                    rd_cnt_d = '0;
                    state_d  = StTx;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = StDrop;
                end
            end
            StTx: begin
                fifo_sel = 1'b1;
                // rd_cnt stays below pkt_len here, so the increment cannot overflow.
                rd_en    = tx_ready && (rd_cnt_q < pkt_len_q);
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + One;
                    last_rd  = (rd_cnt_q + One == pkt_len_q);
                    if (last_rd) begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                drop_packet = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Writes arriving while back-pressured are ignored apart from flagging the violation.
        if (stall && wr_en) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pkt_len_q  <= '0;
            pkt_base_q <= '0;
            rd_cnt_q   <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_len_q  <= pkt_len_d;
            pkt_base_q <= pkt_base_d;
            rd_cnt_q   <= rd_cnt_d;
            err_q      <= err_d;
            tx_valid_q <= rd_en;
            tx_last_q  <= last_rd;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign pkt_base = pkt_base_q;
    assign pkt_len  = pkt_len_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pkt_seq_ctrl.sv
// Bench for pkt_seq_ctrl: vector table, hand-written corner sequences, randomized packets vs model.
module tb_pkt_seq_ctrl;

    localparam int unsigned AW      = 4;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned TIMEOUT = 16;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [7:0]    wr_ctrl;
    logic          fifo_full;
    logic [AW:0]   tail_addr;
    logic          proc_done;
    logic          proc_drop;
    logic          tx_ready;
    logic          fifo_sel;
    logic          rd_en;
    logic          drop_packet;
    logic          stall;
    logic          tx_valid;
    logic          tx_last;
    logic [AW:0]   pkt_base;
    logic [AW:0]   pkt_len;
    logic          err;
    logic [16:0]   all_out;
    logic [6:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_err;

    pkt_seq_ctrl #(
        .AWIDTH  (AW),
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_ctrl     (wr_ctrl),
        .fifo_full   (fifo_full),
        .tail_addr   (tail_addr),
        .proc_done   (proc_done),
        .proc_drop   (proc_drop),
        .tx_ready    (tx_ready),
        .fifo_sel    (fifo_sel),
        .rd_en       (rd_en),
        .drop_packet (drop_packet),
        .stall       (stall),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .pkt_base    (pkt_base),
        .pkt_len     (pkt_len),
        .err         (err)
    );

    assign flags   = {fifo_sel, stall, rd_en, drop_packet, tx_valid, tx_last, err};
    assign all_out = {flags, pkt_base, pkt_len};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1);
    end

    typedef struct {
        logic       we;
        logic [7:0] ctrl;
        logic       full;
        logic       done;
        logic       drop;
        logic       rdy;
        logic [6:0] exp_flags;
        logic [4:0] exp_len;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (wr_en) tail_addr = tail_addr + 5'd1;
    endtask

    task automatic clear_inputs();
        wr_en     = 1'b0;
        wr_ctrl   = 8'h00;
        fifo_full = 1'b0;
        proc_done = 1'b0;
        proc_drop = 1'b0;
        tx_ready  = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset_n = 1'b0;
        adv();
        adv();
        reset_n = 1'b1;
        exp_err = 1'b0;
    endtask

    task automatic wr_word(input logic [7:0] ctrl);
        wr_en   = 1'b1;
        wr_ctrl = ctrl;
        adv();
        wr_en   = 1'b0;
        wr_ctrl = 8'h00;
    endtask

    // One random packet: expected outcome derived from the packet rules, not cycle-by-cycle.
    task automatic run_packet();
        int         n, full_at, stop_w, stop_kind, action, k, reads, valids, gate_bad, last_bad;
        logic       eop_flag, fin;
        logic [7:0] ctrl, eop_code;
        logic [4:0] base;
        eop_flag = ($urandom_range(0, 4) != 0);
        n        = eop_flag ? int'($urandom_range(2, 5)) : int'($urandom_range(5, 6));
        full_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, n - 1)) : 0;
        eop_code = 8'($urandom_range(1, 254));
        stop_w   = 0;
        stop_kind = 0;
        for (int i = 1; i <= n; i++) begin
            if (stop_w == 0) begin
                if (i == n && eop_flag) begin
                    stop_w = i; stop_kind = 0;
                end else if (i >= 2 && i >= int'(MAX_LEN)) begin
                    stop_w = i; stop_kind = 1;
                end else if (i == full_at) begin
                    stop_w = i; stop_kind = 2;
                end
            end
        end
        base = tail_addr;
        for (int i = 1; i <= stop_w; i++) begin
            ctrl = (i == 1) ? 8'hFF : ((i == n && eop_flag) ? eop_code : 8'h00);
            wr_word(ctrl);
            if (i < stop_w) repeat ($urandom_range(0, 2)) adv();
        end
        if (stop_kind == 2) begin
            fifo_full = 1'b1;
            adv();
            fifo_full = 1'b0;
        end
        if (stop_kind != 0) begin
            exp_err = 1'b1;
            sample();
            check("rnd_recv_drop", 32'(drop_packet), 32'd1);
            check("rnd_recv_err", 32'(err), 32'd1);
            if (stop_kind == 1) check("rnd_ovf_len", 32'(pkt_len), 32'(stop_w));
            adv();
        end else begin
            sample();
            check("rnd_proc_len", 32'(pkt_len), 32'(n));
            check("rnd_proc_base", 32'(pkt_base), 32'(base));
            check("rnd_proc_own", 32'({stall, fifo_sel}), 32'b10);
            action = $urandom_range(0, 4);
            if (action == 4) begin
                k = 0;
                while (!drop_packet && k < 40) begin
                    adv();
                    k++;
                    sample();
                end
                exp_err = 1'b1;
                check("rnd_timeout_cycle", 32'(k), 32'(TIMEOUT));
                check("rnd_timeout_err", 32'(err), 32'd1);
                adv();
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    if ($urandom_range(0, 5) == 0) begin
                        wr_en   = 1'b1;
                        exp_err = 1'b1;
                    end
                    adv();
                    wr_en = 1'b0;
                end
                proc_done = (action != 2);
                proc_drop = (action >= 2);
                adv();
                proc_done = 1'b0;
                proc_drop = 1'b0;
                if (action >= 2) begin
                    sample();
                    check("rnd_proc_drop", 32'(drop_packet), 32'd1);
                    check("rnd_drop_no_rd", 32'(rd_en), 32'd0);
                    adv();
                end else begin
                    reads = 0; valids = 0; gate_bad = 0; last_bad = 0; k = 0; fin = 1'b0;
                    while (!fin && k < 200) begin
                        tx_ready = 1'($urandom_range(0, 1));
                        sample();
                        if (rd_en) reads++;
                        if (rd_en && !tx_ready) gate_bad++;
                        if (tx_valid) begin
                            valids++;
                            if (tx_last != (valids == n)) last_bad++;
                        end else if (tx_last) begin
                            last_bad++;
                        end
                        if (valids == n) begin
                            fin = 1'b1;
                            check("rnd_tx_idle_after", 32'(stall), 32'd0);
                        end
                        adv();
                        k++;
                    end
                    tx_ready = 1'b0;
                    check("rnd_tx_reads", 32'(reads), 32'(n));
                    check("rnd_tx_valids", 32'(valids), 32'(n));
                    check("rnd_tx_gate", 32'(gate_bad), 32'd0);
                    check("rnd_tx_last", 32'(last_bad), 32'd0);
                end
            end
        end
        sample();
        check("rnd_err_sticky", 32'(err), 32'(exp_err));
        adv();
    endtask

    initial begin
        int         k, reads, valids, bad;
        logic [4:0] base;
        clear_inputs();
        reset_n   = 1'b0;
        tail_addr = 5'($urandom_range(0, 31));
        exp_err   = 1'b0;
        reset_dut();
        sample();
        check("reset_state", 32'(all_out), 32'd0);
        adv();

        // {we, ctrl, full, done, drop, rdy, {fifo_sel,stall,rd_en,drop,tx_valid,tx_last,err}, len}
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd0};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd1};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd2};
        vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd3};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0100000, 5'd4};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100000, 5'd4};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110000, 5'd4};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110100, 5'd4};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110100, 5'd4};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110100, 5'd4};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110, 5'd4};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd4};
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd4};
        vecs[13] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0100000, 5'd2};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0101000, 5'd2};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd2};
        vecs[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 5'd2};
        vecs[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0101001, 5'd2};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001, 5'd2};

        for (int i = 0; i < 20; i++) begin
            wr_en     = vecs[i].we;
            wr_ctrl   = vecs[i].ctrl;
            fifo_full = vecs[i].full;
            proc_done = vecs[i].done;
            proc_drop = vecs[i].drop;
            tx_ready  = vecs[i].rdy;
            sample();
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_len", i), 32'(pkt_len), 32'(vecs[i].exp_len));
            adv();
        end
        clear_inputs();

        // Overflow at MAX_LEN words without EOP.
        reset_dut();
        base = tail_addr;
        wr_word(8'hFF);
        wr_word(8'h00);
        wr_word(8'h00);
        sample();
        check("ovf_not_early", 32'({drop_packet, stall}), 32'd0);
        wr_word(8'h00);
        wr_en = 1'b1;
        sample();
        check("ovf_drop", 32'(drop_packet), 32'd1);
        check("ovf_stall", 32'(stall), 32'd1);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_len", 32'(pkt_len), 32'd4);
        check("ovf_base", 32'(pkt_base), 32'(base));
        adv();
        wr_en = 1'b0;
        sample();
        check("ovf_one_cycle", 32'({drop_packet, stall}), 32'd0);
        adv();

        // PROC timeout with no processor response.
        reset_dut();
        wr_word(8'hFF);
        wr_word(8'h01);
        k = 0;
        bad = 0;
        sample();
        while (!drop_packet && k < 40) begin
            if (rd_en) bad++;
            adv();
            k++;
            sample();
        end
        check("timeout_cycle", 32'(k), 32'(TIMEOUT));
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_no_rd", 32'(bad), 32'd0);
        adv();

        // TX under alternating tx_ready.
        reset_dut();
        wr_word(8'hFF);
        wr_word(8'h00);
        wr_word(8'h05);
        proc_done = 1'b1;
        adv();
        proc_done = 1'b0;
        reads = 0; valids = 0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            tx_ready = (c % 2 == 0);
            sample();
            if (rd_en) reads++;
            if (rd_en && !tx_ready) bad++;
            if (tx_valid) valids++;
            adv();
        end
        tx_ready = 1'b0;
        check("toggle_reads", 32'(reads), 32'd3);
        check("toggle_valids", 32'(valids), 32'd3);
        check("toggle_gate", 32'(bad), 32'd0);

        // Reset in the middle of a drain.
        wr_word(8'hFF);
        wr_word(8'h02);
        proc_done = 1'b1;
        adv();
        proc_done = 1'b0;
        tx_ready  = 1'b1;
        sample();
        check("midtx_rd", 32'(rd_en), 32'd1);
        reset_n = 1'b0;
        adv();
        reset_n = 1'b1;
        sample();
        check("midtx_reset_out", 32'(all_out), 32'd0);
        adv();
        sample();
        check("midtx_quiet", 32'(all_out), 32'd0);
        tx_ready = 1'b0;
        adv();

        reset_dut();
        for (int p = 0; p < 60; p++) run_packet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_seq_ctrl.md
PKT_SEQ_CTRL -- requirements
Module: pkt_seq_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 8, FIFO word-address width; the pointer is AWIDTH+1 bits, with the MSB as the wrap bit.
REQ-002 SHALL have parameter MAX_LEN, default 200, the maximum words per packet.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum cycles the processor may own a packet.
REQ-004 SHALL have parameter SOP_CTRL, default 8'hFF, the ctrl code marking the first word; any other nonzero ctrl marks the last word (EOP).
REQ-005 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port wr_en  in  1  a word is written into the FIFO this cycle.
REQ-008 SHALL have port wr_ctrl  in  8  ctrl byte of the written word.
REQ-009 SHALL have port fifo_full  in  1  FIFO full/almost-full indication.
REQ-010 SHALL have port tail_addr  in  AWIDTH+1  current FIFO write pointer.
REQ-011 SHALL have port proc_done  in  1  pulse: processor finished the packet, transmit it.
REQ-012 SHALL have port proc_drop  in  1  pulse: processor discards the packet.
REQ-013 SHALL have port tx_ready  in  1  downstream accepts a word.
REQ-014 SHALL have port fifo_sel  out  1  1 = FIFO drain owns SRAM port B; 0 = processor owns it.
REQ-015 SHALL have port rd_en  out  1  advance the FIFO head; data appears 1 cycle later.
REQ-016 SHALL have port drop_packet  out  1  one-cycle pulse: head <= tail.
REQ-017 SHALL have port stall  out  1  back-pressure to the packet source.
REQ-018 SHALL have port tx_valid  out  1  SRAM read data is valid this cycle.
REQ-019 SHALL have port tx_last  out  1  qualifies the final tx_valid word of a packet.
REQ-020 SHALL have port pkt_base  out  AWIDTH+1  tail_addr captured on the SOP word.
REQ-021 SHALL have port pkt_len  out  AWIDTH+1  words in the current packet.
REQ-022 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-023 SHALL implement the states IDLE, RECV, PROC, TX and DROP; the state register is the only state-bearing element besides the counters.
REQ-024 In IDLE, wr_en with SOP_CTRL SHALL capture pkt_base, set pkt_len=1 and go to RECV; if the same word is also EOP-coded, it SHALL go directly to PROC.
REQ-025 In IDLE, wr_en without SOP SHALL set err and go to DROP.
REQ-026 In RECV, each wr_en SHALL increment pkt_len; a word with nonzero ctrl other than SOP_CTRL (EOP) SHALL go to PROC.
REQ-027 In RECV, a SOP word, fifo_full=1, or pkt_len reaching MAX_LEN without EOP SHALL set err and go to DROP.
REQ-028 In PROC, fifo_sel SHALL be 0, stall SHALL be 1, and the timer SHALL count from 0.
- proc_drop -> DROP.
- Else proc_done -> TX.
- Timer reaching TIMEOUT-1 -> DROP with err set.
- proc_drop and proc_done in the same cycle: drop wins.
REQ-029 In TX, fifo_sel=1 and stall=1; rd_en = tx_ready AND rd_cnt<pkt_len.
- The state SHALL go to IDLE in the cycle the last rd_en issues.
REQ-030 tx_valid SHALL equal rd_en delayed 1 cycle; tx_last SHALL equal (last rd_en) delayed 1 cycle.
REQ-031 In DROP, drop_packet SHALL be 1 and stall=1 for exactly one cycle, then the state SHALL go to IDLE.
- Because DROP is entered one cycle after the offending write, tail_addr already includes that word.
REQ-032 stall SHALL be 0 only in IDLE and RECV; wr_en while stall=1 SHALL set err and be otherwise ignored.
REQ-033 pkt_len, rd_cnt and the timer SHALL be AWIDTH+1 bits (timer sized by TIMEOUT) and SHALL saturate, never wrap.
- pkt_base SHALL be unsigned mod 2^(AWIDTH+1), following pointer wrap.
REQ-034 err SHALL remain set until reset.

Reset
REQ-035 reset_n=0 at a clock edge SHALL force IDLE and clear all counters, err and pkt_base; every output SHALL be 0, including mid-TX or mid-PROC, with no drop pulse issued.

Structure
REQ-036 A shared package pkt_seq_pkg SHALL hold the state enum, the SOP_CTRL default and the EOP decode constant.
REQ-037 The PROC timeout SHALL be one sub-module, pkt_seq_timer, with ports clear, enable and expired.

Verification
REQ-038 SOP(FF), 2 mid words, EOP(01) -> PROC, pkt_len=4; proc_done with tx_ready=1 -> 4 rd_en cycles, tx_valid x4, tx_last on the 4th, then IDLE.
REQ-039 Single word with ctrl=FF then EOP on the same word -> PROC with pkt_len=1 directly; proc_drop -> drop_packet pulse 1 cycle, err=0.
REQ-040 MAX_LEN=4, 5 words without EOP -> DROP after the 4th word, err=1, stall=1 for 1 cycle.
REQ-041 TIMEOUT=16, no proc_done -> drop_packet on cycle 16 of PROC; proc_done+proc_drop together -> drop, no rd_en.
REQ-042 tx_ready toggling 1/0 during a 3-word TX -> rd_en only when ready, exactly 3 reads; reset mid-TX -> all outputs 0 next cycle.
